// File: rtl/etapa_if_id.sv
// -----------------------------------------------------------------------------
// etapa_if_id
// IF/ID pipeline register with load-use hazard detection and performance
// counters. State updates on the falling edge of i_clk so it lines up with the
// downstream ID/EX register.
//
// Ports:
//   i_clk          clock (falling-edge active)
//   i_reset        asynchronous active-low reset
//   i_Enable       global advance enable; 0 freezes all state
//   i_PC4          PC+4 from fetch
//   i_Instruction  fetched instruction word
//   i_Flush        taken control transfer; squash held instruction
//   i_EX_MemRead   MemRead of the instruction in ID/EX
//   i_EX_Rt        destination Rt of the instruction in ID/EX
//   o_PC4          registered PC+4
//   o_Instruction  registered instruction
//   o_Valid        held instruction is real (not a bubble)
//   o_Stall        load-use hazard (combinational)
//   o_StallCount   saturating count of stalled cycles
//   o_FlushCount   saturating count of applied flushes
// -----------------------------------------------------------------------------
module etapa_if_id #(
  parameter int unsigned NBITS   = 32,
  parameter int unsigned RNBITS  = 5,
  parameter int unsigned CNTBITS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_Enable,
  input  logic [NBITS-1:0]   i_PC4,
  input  logic [NBITS-1:0]   i_Instruction,
  input  logic               i_Flush,
  input  logic               i_EX_MemRead,
  input  logic [RNBITS-1:0]  i_EX_Rt,
  output logic [NBITS-1:0]   o_PC4,
  output logic [NBITS-1:0]   o_Instruction,
  output logic               o_Valid,
  output logic               o_Stall,
  output logic [CNTBITS-1:0] o_StallCount,
  output logic [CNTBITS-1:0] o_FlushCount
);

  localparam logic [CNTBITS-1:0] CntOne = CNTBITS'(1);
  localparam logic [CNTBITS-1:0] CntMax = '1;

  logic [NBITS-1:0]   r_pc4;
  logic [NBITS-1:0]   r_instr;
  logic               r_valid;
  logic [CNTBITS-1:0] r_stall_cnt;
  logic [CNTBITS-1:0] r_flush_cnt;

  logic [RNBITS-1:0]  w_rs;
  logic [RNBITS-1:0]  w_rt;
  logic               w_stall;

  assign w_rs = r_instr[21 +: RNBITS];
  assign w_rt = r_instr[16 +: RNBITS];

  // Register 0 is never a real dependency, so a load into r0 never stalls.
  assign w_stall = r_valid & i_EX_MemRead & (i_EX_Rt != '0) &
                   ((i_EX_Rt == w_rs) | (i_EX_Rt == w_rt));

  always_ff @(negedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pc4       <= '0;
      r_instr     <= '0;
      r_valid     <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (i_Enable) begin
      if (i_Flush) begin
        // Flush beats stall: the held word is squashed to a NOP bubble.
        r_pc4   <= i_PC4;
        r_instr <= '0;
        r_valid <= 1'b0;
        if (r_flush_cnt != CntMax) r_flush_cnt <= r_flush_cnt + CntOne;
      end else if (w_stall) begin
        if (r_stall_cnt != CntMax) r_stall_cnt <= r_stall_cnt + CntOne;
      end else begin
        r_pc4   <= i_PC4;
        r_instr <= i_Instruction;
        r_valid <= 1'b1;
      end
    end
  end

  assign o_PC4         = r_pc4;
  assign o_Instruction = r_instr;
  assign o_Valid       = r_valid;
  assign o_Stall       = w_stall;
  assign o_StallCount  = r_stall_cnt;
  assign o_FlushCount  = r_flush_cnt;

endmodule

// File: doc/etapa_if_id.md
ETAPA_IF_ID -- requirements
Module: etapa_if_id

Interface
REQ-001 Parameter NBITS, default 32, datapath width (PC4, instruction).
REQ-002 Parameter RNBITS, default 5, register-index width.
REQ-003 Parameter CNTBITS, default 16, width of the performance counters.
REQ-004 i_clk  input  1  single clock; all state updates on the falling edge, aligned with the downstream ID/EX register.
REQ-005 i_reset  input  1  reset, asynchronous, active-low.
REQ-006 i_Enable  input  1  global advance enable (debug step); 0 freezes all state.
REQ-007 i_PC4  input  NBITS  PC+4 from fetch.
REQ-008 i_Instruction  input  NBITS  fetched instruction word.
REQ-009 i_Flush  input  1  control-transfer taken; squash the held instruction.
REQ-010 i_EX_MemRead  input  1  MemRead of the instruction currently in ID/EX.
REQ-011 i_EX_Rt  input  RNBITS  destination Rt of the instruction currently in ID/EX.
REQ-012 o_PC4  output  NBITS  registered PC+4 to decode.
REQ-013 o_Instruction  output  NBITS  registered instruction to decode.
REQ-014 o_Valid  output  1  held instruction is real (not a bubble).
REQ-015 o_Stall  output  1  load-use hazard: freeze PC, inject bubble into ID/EX controls.
REQ-016 o_StallCount  output  CNTBITS  cycles stalled.
REQ-017 o_FlushCount  output  CNTBITS  flushes applied.

Function
REQ-018 Fields of held word: rs = o_Instruction[25:21], rt = o_Instruction[20:16].
REQ-019 o_Stall = o_Valid & i_EX_MemRead & (i_EX_Rt != 0) & ((i_EX_Rt == rs) | (i_EX_Rt == rt)); combinational, no registering.
REQ-020 Falling edge with i_Enable=1, priority i_Flush > o_Stall > load.
REQ-021 Flush: o_Instruction <= 0 (NOP), o_Valid <= 0, o_PC4 <= i_PC4; o_FlushCount increments.
REQ-022 Stall (no flush): o_PC4, o_Instruction, o_Valid hold; o_StallCount increments.
REQ-023 Load (neither): o_PC4 <= i_PC4, o_Instruction <= i_Instruction, o_Valid <= 1.
REQ-024 Flush and stall in same cycle: flush wins; o_StallCount does not increment; o_Stall drops next cycle since o_Valid=0.
REQ-025 i_Enable=0: every register holds, both counters hold, regardless of i_Flush/o_Stall; o_Stall still reflects current inputs.
REQ-026 Counters saturate at 2^CNTBITS-1; no wrap.
REQ-027 Latency: input captured on edge N appears at outputs immediately after edge N (one stage).
REQ-028 A single load-use hazard stalls exactly one cycle, given downstream bubble clears i_EX_MemRead.

Reset
REQ-029 i_reset=0 asynchronously forces o_PC4=0, o_Instruction=0, o_Valid=0, o_StallCount=0, o_FlushCount=0, independent of i_clk.
REQ-030 While i_reset=0 no capture occurs; first capture on first falling edge after i_reset rises.
REQ-031 Reset mid-stall or mid-flush discards held instruction; o_Stall=0 during reset since o_Valid=0.

Verification
REQ-032 Load: i_PC4=0x4, i_Instruction=0x8C220000, enable=1, one falling edge -> o_PC4=0x4, o_Instruction=0x8C220000, o_Valid=1, o_Stall=0.
REQ-033 Load-use: held 0x00431020 (add r2,r2,r3: rs=2,rt=3), i_EX_MemRead=1, i_EX_Rt=2 -> o_Stall=1, held for one edge, o_StallCount=1; then i_EX_MemRead=0 -> o_Stall=0, next word loads.
REQ-034 Rt=0 guard: i_EX_MemRead=1, i_EX_Rt=0, held rs=0 -> o_Stall=0.
REQ-035 Flush with stall: o_Stall=1 and i_Flush=1 same edge -> o_Instruction=0, o_Valid=0, o_FlushCount=1, o_StallCount unchanged.
REQ-036 Enable freeze: i_Enable=0, i_Flush=1, new i_Instruction over 3 edges -> all outputs and counters unchanged.
REQ-037 Async reset: assert i_reset=0 between clock edges with o_Valid=1, counters nonzero -> all outputs 0 immediately; saturation: preload counter to 0xFFFF via 65535 stalls, one more stall -> stays 0xFFFF.
